// File: rtl/mmio_bridge_if.sv
// CPU-side data-memory request/response plus DRAM-side port of the MMIO bridge.
// Latency: none; every signal is a plain wire bundle.
// Backpressure: none; the core issues one access per cycle and DRAM reads are combinational.
interface mmio_bridge_if #(
  parameter int DRAM_AW = 14
);
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_wdata;
  logic               cpu_we;
  logic [31:0]        cpu_rdata;
  logic [DRAM_AW-1:0] dram_addr;
  logic [31:0]        dram_wdata;
  logic               dram_we;
  logic [31:0]        dram_rdata;

  // Bridge side: consumes the core request, drives DRAM.
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, dram_rdata,
    output cpu_rdata, dram_addr, dram_wdata, dram_we
  );

  // Environment side: the core plus the DRAM model.
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, dram_rdata,
    input  cpu_rdata, dram_addr, dram_wdata, dram_we
  );
endinterface

// File: rtl/mmio_bridge.sv
// Routes core loads/stores to DRAM or the peripheral page; owns LED, switch sync, 7-seg scan.
// Latency: loads are zero-cycle; stores land on the next clk edge; switches appear 2 cycles late.
// Backpressure: none. Define MMIO_TIMER_EN to add the free-running cycle counter at 0xFFFFF020.
module mmio_bridge #(
  parameter int DRAM_AW  = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_bridge_if.slave       bus,
  input  logic [23:0]        sw,
  output logic [23:0]        led,
  output logic [7:0]         seg_an,
  output logic [7:0]         seg_ca
);

  localparam logic [31:0] ADDR_DISP = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TMR  = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
  localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

  logic        periph_hit;
  logic        hit_disp, hit_led, hit_sw;
  logic        wr_disp, wr_led;

  logic [31:0] disp_q, disp_d;
  logic [23:0] led_q, led_d;
  logic [23:0] sw_s1_q, sw_s2_q;
  logic [19:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  dig_q, dig_d;
  logic [3:0]  nibble;
  logic [6:0]  seg_abcdefg;

  assign periph_hit = (bus.cpu_addr[31:12] == 20'hFFFFF);
  assign hit_disp   = (bus.cpu_addr == ADDR_DISP);
  assign hit_led    = (bus.cpu_addr == ADDR_LED);
  assign hit_sw     = (bus.cpu_addr == ADDR_SW);
  assign wr_disp    = bus.cpu_we & hit_disp;
  assign wr_led     = bus.cpu_we & hit_led;

  // DRAM sees the request unregistered; a store is gated off for the peripheral page and in reset.
  assign bus.dram_addr  = bus.cpu_addr[DRAM_AW+1:2];
  assign bus.dram_wdata = bus.cpu_wdata;
  assign bus.dram_we    = bus.cpu_we & ~periph_hit & rst_n;

`ifdef MMIO_TIMER_EN
  logic        hit_tmr;
  logic [31:0] timer_q, timer_d;

  assign hit_tmr = (bus.cpu_addr == ADDR_TMR);

  // Counter free-runs; a store overrides that cycle's increment.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (bus.cpu_we && hit_tmr) timer_d = bus.cpu_wdata;
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_q <= 32'h0;
    else        timer_q <= timer_d;
  end
`endif

  // Load data: DRAM outside the page, register contents inside, zero for unmapped offsets.
  always_comb begin
    bus.cpu_rdata = 32'h0;
    if (!periph_hit)   bus.cpu_rdata = bus.dram_rdata;
    else if (hit_disp) bus.cpu_rdata = disp_q;
    else if (hit_led)  bus.cpu_rdata = {8'h0, led_q};
    else if (hit_sw)   bus.cpu_rdata = {8'h0, sw_s2_q};
`ifdef MMIO_TIMER_EN
    else if (hit_tmr)  bus.cpu_rdata = timer_q;
`endif
  end

  // Next-state for the writable peripheral registers.
  always_comb begin
    disp_d = disp_q;
    led_d  = led_q;
    if (wr_disp) disp_d = bus.cpu_wdata;
    if (wr_led)  led_d  = bus.cpu_wdata[23:0];
  end

  // Peripheral registers and the two-flop switch synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q  <= 32'h0;
      led_q   <= 24'h0;
      sw_s1_q <= 24'h0;
      sw_s2_q <= 24'h0;
    end else begin
      disp_q  <= disp_d;
      led_q   <= led_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Scan timing: each digit stays lit SCAN_DIV cycles, then the next digit takes over.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 20'd1;
    dig_d      = dig_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 20'h0;
      dig_d      = dig_q + 3'd1;
    end
  end

  // Scan counter and digit index; a DISP store deliberately leaves these alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= 20'h0;
      dig_q      <= 3'd0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
    end
  end

  assign nibble = disp_q[4*dig_q +: 4];

  // Hex to segment pattern, abcdefg order with 1 = lit.
  always_comb begin
    seg_abcdefg = 7'b0000000;
    case (nibble)
      4'h0: seg_abcdefg = 7'b1111110;
      4'h1: seg_abcdefg = 7'b0110000;
      4'h2: seg_abcdefg = 7'b1101101;
      4'h3: seg_abcdefg = 7'b1111001;
      4'h4: seg_abcdefg = 7'b0110011;
      4'h5: seg_abcdefg = 7'b1011011;
      4'h6: seg_abcdefg = 7'b1011111;
      4'h7: seg_abcdefg = 7'b1110000;
      4'h8: seg_abcdefg = 7'b1111111;
      4'h9: seg_abcdefg = 7'b1111011;
      4'hA: seg_abcdefg = 7'b1110111;
      4'hB: seg_abcdefg = 7'b0011111;
      4'hC: seg_abcdefg = 7'b1001110;
      4'hD: seg_abcdefg = 7'b0111101;
      4'hE: seg_abcdefg = 7'b1001111;
      default: seg_abcdefg = 7'b1000111;
    endcase
  end

  // Board pins are active-low; seg_ca packs {dp,g,f,e,d,c,b,a} with dp held dark.
  assign seg_ca = {1'b1, ~seg_abcdefg[0], ~seg_abcdefg[1], ~seg_abcdefg[2], ~seg_abcdefg[3],
                   ~seg_abcdefg[4], ~seg_abcdefg[5], ~seg_abcdefg[6]};
  assign seg_an = ~(8'b1 << dig_q);
  assign led    = led_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: DRAM routing, LED/DISP/SW registers, timer, scan, async reset.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Expected values are hand-derived constants; the scan uses a tiny digit/pattern table.
module tb_mmio_bridge;

`ifdef MMIO_TIMER_EN
  localparam bit TMR_ON = 1'b1;
`else
  localparam bit TMR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_ca;
  int          checks;
  int          errors;

  mmio_bridge_if #(.DRAM_AW(14)) bus ();

  mmio_bridge #(.DRAM_AW(14), .SCAN_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sw     (sw),
    .led    (led),
    .seg_an (seg_an),
    .seg_ca (seg_ca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = we;
  endtask

  initial begin
    logic [7:0] ca_exp;
    logic [7:0] an_exp;
    logic [7:0] one8;
    int         dg;

    checks = 0;
    errors = 0;
    one8   = 8'h01;
    rst_n  = 1'b0;
    sw     = 24'h0;
    bus.dram_rdata = 32'h5A5A_1234;
    drive(32'h0000_0010, 32'h1111_2222, 1'b1);

    // Reset state, with a DRAM store held on the bus.
    #1;
    chk("rst_led",    {8'h0, led}, 32'h0);
    chk("rst_an",     {24'h0, seg_an}, 32'hFE);
    chk("rst_ca",     {24'h0, seg_ca}, 32'hC0);
    chk("rst_dram_we", {31'h0, bus.dram_we}, 32'h0);
    chk("rst_rdata",  bus.cpu_rdata, 32'h5A5A_1234);
    chk("rst_daddr",  {18'h0, bus.dram_addr}, 32'h4);

    @(negedge clk);
    rst_n = 1'b1;

    // DRAM store then load.
    drive(32'h0000_0010, 32'h1234_5678, 1'b1);
    #1;
    chk("dram_we_st", {31'h0, bus.dram_we}, 32'h1);
    chk("dram_addr",  {18'h0, bus.dram_addr}, 32'h4);
    chk("dram_wdata", bus.dram_wdata, 32'h1234_5678);
    @(negedge clk);
    drive(32'h0000_0010, 32'h0, 1'b0);
    bus.dram_rdata = 32'hCAFE_F00D;
    #1;
    chk("dram_ld",    bus.cpu_rdata, 32'hCAFE_F00D);
    chk("dram_we_ld", {31'h0, bus.dram_we}, 32'h0);

    // LED store: DRAM must not see it; visible next cycle.
    @(negedge clk);
    drive(32'hFFFF_F060, 32'h00AB_CDEF, 1'b1);
    #1;
    chk("led_st_we",  {31'h0, bus.dram_we}, 32'h0);
    chk("led_pre",    {8'h0, led}, 32'h0);
    @(negedge clk);
    drive(32'hFFFF_F060, 32'h0, 1'b0);
    #1;
    chk("led_val",    {8'h0, led}, 32'h00AB_CDEF);
    chk("led_rd",     bus.cpu_rdata, 32'h00AB_CDEF);

    // Store to unmapped offset 0x064.
    @(negedge clk);
    drive(32'hFFFF_F064, 32'h1234_5678, 1'b1);
    #1;
    chk("unm_st_we",  {31'h0, bus.dram_we}, 32'h0);
    @(negedge clk);
    drive(32'hFFFF_F064, 32'h0, 1'b0);
    #1;
    chk("unm_led",    {8'h0, led}, 32'h00AB_CDEF);
    chk("unm_rd",     bus.cpu_rdata, 32'h0);

    // DISP read/write.
    @(negedge clk);
    drive(32'hFFFF_F000, 32'hDEAD_BEEF, 1'b1);
    #1;
    chk("disp_st_we", {31'h0, bus.dram_we}, 32'h0);
    @(negedge clk);
    drive(32'hFFFF_F000, 32'h0, 1'b0);
    #1;
    chk("disp_rd",    bus.cpu_rdata, 32'hDEAD_BEEF);

    // Switch synchroniser: two cycles before the new value reads back.
    @(negedge clk);
    sw = 24'h00F00F;
    drive(32'hFFFF_F070, 32'h0, 1'b0);
    #1;
    chk("sw_c0", bus.cpu_rdata, 32'h0);
    @(negedge clk);
    #1;
    chk("sw_c1", bus.cpu_rdata, 32'h0);
    @(negedge clk);
    #1;
    chk("sw_c2", bus.cpu_rdata, 32'h0000_F00F);

    // Timer store and wrap (reads zero when the counter is not built).
    @(negedge clk);
    drive(32'hFFFF_F020, 32'hFFFF_FFFE, 1'b1);
    #1;
    chk("tmr_st_we", {31'h0, bus.dram_we}, 32'h0);
    @(negedge clk);
    drive(32'hFFFF_F020, 32'h0, 1'b0);
    #1;
    chk("tmr_r0", bus.cpu_rdata, TMR_ON ? 32'hFFFF_FFFE : 32'h0);
    @(negedge clk);
    #1;
    chk("tmr_r1", bus.cpu_rdata, TMR_ON ? 32'hFFFF_FFFF : 32'h0);
    @(negedge clk);
    #1;
    chk("tmr_r2", bus.cpu_rdata, 32'h0);

    // Fresh reset to align the scan; the LED register must clear too.
    @(negedge clk);
    rst_n = 1'b0;
    drive(32'hFFFF_F000, 32'h0, 1'b0);
    #1;
    chk("rst2_led", {8'h0, led}, 32'h0);
    chk("rst2_an",  {24'h0, seg_an}, 32'hFE);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'hFFFF_F000, 32'h0000_001F, 1'b1);
    #1;
    chk("scan_k0_an", {24'h0, seg_an}, 32'hFE);
    chk("scan_k0_ca", {24'h0, seg_ca}, 32'hC0);

    // k counts rising edges since reset release; digit = (k/4) mod 8.
    for (int k = 1; k <= 53; k++) begin
      @(negedge clk);
      if (k == 40) drive(32'hFFFF_F060, 32'h00AB_CDEF, 1'b1);
      else         drive(32'hFFFF_F000, 32'h0, 1'b0);
      #1;
      dg     = (k / 4) % 8;
      an_exp = ~(one8 << dg);
      ca_exp = (dg == 0) ? 8'h8E : (dg == 1) ? 8'hF9 : 8'hC0;
      chk($sformatf("scan_k%0d_an", k), {24'h0, seg_an}, {24'h0, an_exp});
      chk($sformatf("scan_k%0d_ca", k), {24'h0, seg_ca}, {24'h0, ca_exp});
      if (k == 1)  chk("scan_disp_rd", bus.cpu_rdata, 32'h0000_001F);
      if (k == 41) chk("scan_led", {8'h0, led}, 32'h00AB_CDEF);
    end
    chk("scan_dig5_an", {24'h0, seg_an}, 32'hDF);

    // Asynchronous reset mid-scan, away from any clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_an",  {24'h0, seg_an}, 32'hFE);
    chk("arst_ca",  {24'h0, seg_ca}, 32'hC0);
    chk("arst_led", {8'h0, led}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
